// File: rtl/sum_accumulator.sv
// sum_accumulator: frames the adder's sum stream into totals of LEN samples.
// Samples arrive over a valid/ready handshake. A frame closes when it reaches
// LEN samples or when a flush pulse arrives. The closed frame's total, sample
// count and sticky overflow flag are then held until the consumer pops them.
// Optional feature macro: SUM_ACCUMULATOR_SAT_EN. When it is defined, the
// accumulator clamps to all-ones on overflow. When it is undefined, the
// accumulator wraps modulo 2^AW.
module sum_accumulator #(
  parameter int DW  = 4,
  parameter int AW  = 8,
  parameter int LEN = 4,
  parameter int CW  = 8
) (
  input  logic [1:0]    clock_reset,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  input  logic          flush,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_data,
  output logic [CW-1:0] out_count,
  output logic          out_ovf,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  logic          clk;
  logic          rst_n;
  state_t        state;
  state_t        state_nxt;
  logic          live;
  logic [AW-1:0] acc;
  logic [AW-1:0] acc_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          ovf;
  logic          ovf_nxt;
  logic [AW:0]   sum;
  logic          accept;
  logic          close;

  assign clk   = clock_reset[0];
  assign rst_n = clock_reset[1];

  // Unsigned add with the carry kept in the top bit.
  function automatic logic [AW:0] add_sample(input logic [AW-1:0] a,
                                             input logic [DW-1:0] d);
    return {1'b0, a} + {{(AW+1-DW){1'b0}}, d};
  endfunction

`ifdef SUM_ACCUMULATOR_SAT_EN
  // Once the frame has overflowed, hold the accumulator at full scale.
  function automatic logic [AW-1:0] clamp(input logic [AW:0] s,
                                          input logic sticky);
    return (s[AW] || sticky) ? {AW{1'b1}} : s[AW-1:0];
  endfunction
`endif

  // in_ready, out_valid and busy decode registered state only, so out_ready
  // never reaches them combinationally. The live flag keeps in_ready low
  // until the first clock after reset is released.
  assign in_ready  = live && (state != HOLD);
  assign out_valid = (state == HOLD);
  assign busy      = (state != IDLE);
  assign accept    = in_valid && in_ready;

  // Set the live flag on the first clock after reset is released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) live <= 1'b0;
    else        live <= 1'b1;
  end

  // Next-state logic: accumulate, detect frame close, and pop from HOLD.
  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    ovf_nxt   = ovf;
    sum       = '0;
    close     = 1'b0;
    case (state)
      IDLE, ACCUM: begin
        if (accept) begin
          sum     = add_sample(acc, in_data);
`ifdef SUM_ACCUMULATOR_SAT_EN
          acc_nxt = clamp(sum, ovf);
`else
          acc_nxt = sum[AW-1:0];
`endif
          cnt_nxt = cnt + CW'(1);
          ovf_nxt = ovf | sum[AW];
        end
        // A flush in IDLE closes the frame only if a sample arrives with it.
        if ((accept && (cnt_nxt == CW'(LEN))) ||
            (flush && ((state == ACCUM) || accept)))
          close = 1'b1;
        if (close)
          state_nxt = HOLD;
        else if (cnt_nxt != '0)
          state_nxt = ACCUM;
      end
      HOLD: begin
        if (out_ready) begin
          state_nxt = IDLE;
          acc_nxt   = '0;
          cnt_nxt   = '0;
          ovf_nxt   = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Register the frame state: FSM, accumulator, count and sticky overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      cnt   <= cnt_nxt;
      ovf   <= ovf_nxt;
    end
  end

  // Capture the result fields only when a frame closes, then hold them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
    end else if (close) begin
      out_data  <= acc_nxt;
      out_count <= cnt_nxt;
      out_ovf   <= ovf_nxt;
    end
  end

endmodule

// File: doc/sum_accumulator.md
# sum_accumulator

Downstream consumer of the adder stage: takes the adder's 4-bit sum stream over a valid/ready handshake and accumulates it into frames of LEN samples. When a frame completes, or is cut short by a flush pulse, the block presents the frame total, its sample count and an overflow flag. Results are held until the downstream consumer accepts them. It sits between the adder and the parent kernel's result path.

## Interface
Parameters:
- DW, 4, input sample width (matches adder output)
- AW, 8, accumulator/result width; legal range AW ≥ DW
- LEN, 4, samples per frame; legal range 2..255
- CW, 8, count field width; must satisfy 2^CW > LEN

Ports:
- clock_reset  input  2  bit 0 = clock (rising edge); bit 1 = reset_n, asynchronous assert, active-low, release synchronized externally
- in_valid  input  1  sample present on in_data
- in_data  input  DW  unsigned sample (adder sum)
- in_ready  output  1  block can accept a sample this cycle
- flush  input  1  single-cycle pulse; close the current frame early
- out_valid  output  1  result held on out_* fields
- out_ready  input  1  consumer accepts result
- out_data  output  AW  frame total
- out_count  output  CW  samples in frame (1..LEN)
- out_ovf  output  1  accumulation exceeded AW bits during the frame
- busy  output  1  frame in progress (cnt > 0) or result pending

## Operation
- States: IDLE (cnt = 0), ACCUM (0 < cnt < LEN), HOLD (result pending).
- Accept = in_valid & in_ready.
- in_ready = 1 in IDLE and ACCUM; 0 in HOLD.
- On accept: acc ← acc + in_data (zero-extended to AW+1 internally), cnt ← cnt + 1. ovf is sticky: it is set if the carry out of AW is 1.
- Frame closes when:
  - an accept makes cnt == LEN, or
  - flush is high in ACCUM, or flush is high in IDLE together with an accept.
- On close: latch out_data = final acc, out_count = cnt including any same-cycle sample, out_ovf = sticky ovf; go to HOLD.
- HOLD: out_valid = 1 and out_* are stable. When out_ready is high: out_valid ← 0, acc/cnt/ovf ← 0, go to IDLE. No sample is accepted in the pop cycle.
- flush in IDLE with no accept: ignored. flush in HOLD: ignored.
- Arithmetic: unsigned.
- Reset mid-frame or mid-HOLD: all partial state and any pending result are discarded.

## Timing
- Reset values: in_ready = 0 while reset is asserted, 1 from the first clock after release. out_valid = 0, out_data = 0, out_count = 0, out_ovf = 0, busy = 0. Internal acc/cnt/ovf = 0, state IDLE.
- Latency: out_valid rises on the clock edge that accepts the last sample, or samples the flush.
- Throughput: LEN samples followed by at least 1 HOLD cycle, i.e. LEN+1 cycles per frame with out_ready tied high.
- out_* change only on entry to HOLD. They are held unchanged for any length of out_ready stall.
- in_ready, out_valid and busy are registered-state decodes with no combinational path from out_ready.

## Configuration
- SUM_ACCUMULATOR_SAT_EN
  - Defined: on overflow, acc clamps to 2^AW − 1 and stays there for the rest of the frame; out_ovf is still set.
  - Undefined: acc wraps modulo 2^AW; out_ovf is set.

## Test plan
- Nominal frame (DW=4, AW=8, LEN=4): accepts 3, 4, 3, 4 on consecutive cycles, out_ready = 1 → next cycle out_valid = 1, out_data = 0x0E, out_count = 4, out_ovf = 0; in_ready = 0 for one cycle, then 1.
- Constant adder feed of 7 with in_valid toggling every other cycle → out_data = 0x1C after the 4th accept; gaps do not corrupt acc.
- Backpressure: frame completes with out_ready = 0 for 5 cycles → out_data is stable, in_ready = 0 and in_valid is ignored throughout. Pop on cycle 6; the next frame starts from acc = 0.
- Flush:
  - accept 5 and 6, then flush alone → out_data = 11, out_count = 2.
  - flush plus accept of 9 in IDLE → out_data = 9, out_count = 1.
  - flush in IDLE with no accept → no output.
- Overflow (AW=5, LEN=4): samples 15, 15, 15, 15 → out_ovf = 1; out_data = 28 with the macro undefined, 31 with SUM_ACCUMULATOR_SAT_EN defined.
- Reset mid-frame after 2 samples, and again during HOLD → out_valid = 0, busy = 0. The next full frame 1, 1, 1, 1 → out_data = 4, out_count = 4.
